moonbase_bus_responder: RTL and testbench



---
 rtl/moonbase_bus_responder_pkg.sv | 18 +
 rtl/moonbase_nibble_ram.sv | 40 ++++
 rtl/moonbase_bus_responder.sv | 83 ++++++++
 tb/tb_moonbase_bus_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/moonbase_bus_responder_pkg.sv
// Shared constants and types for the moonbase CPU pin-bus responder.
// Bus bit positions, memory space encodings and the nibble-plane selector.
package moonbase_bus_responder_pkg;

  localparam int STROBE = 7;
  localparam int SPACE  = 6;
  localparam int RAM_WN = 5;
  localparam int DEV_WN = 4;

  localparam logic CODE_SPACE = 1'b1;
  localparam logic DATA_SPACE = 1'b0;

  typedef enum logic {
    NIB_LO = 1'b0,
    NIB_HI = 1'b1
  } nib_e;

endpackage

// File: rtl/moonbase_nibble_ram.sv
// Two-plane byte store: one nibble-write port for the CPU, one byte-write port
// for the loader, and an asynchronous nibble read port.
module moonbase_nibble_ram
  import moonbase_bus_responder_pkg::*;
#(
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 nib_we,
  input  nib_e                 nib_plane,
  input  logic [ADDR_BITS:0]   nib_addr,
  input  logic [3:0]           nib_data,
  input  logic                 byte_we,
  input  logic [ADDR_BITS:0]   byte_addr,
  input  logic [7:0]           byte_data,
  input  nib_e                 rd_plane,
  input  logic [ADDR_BITS:0]   rd_addr,
  output logic [3:0]           rd_data
);

  localparam int DEPTH = 2 ** (ADDR_BITS + 1);

  logic [3:0] lo_mem [0:DEPTH-1];
  logic [3:0] hi_mem [0:DEPTH-1];

  // The top never enables both ports in the same cycle, so ordering is moot.
  always_ff @(posedge clk) begin
    if (nib_we) begin
      if (nib_plane == NIB_LO) lo_mem[nib_addr] <= nib_data;
      else                     hi_mem[nib_addr] <= nib_data;
    end
    if (byte_we) begin
      lo_mem[byte_addr] <= byte_data[3:0];
      hi_mem[byte_addr] <= byte_data[7:4];
    end
  end

  assign rd_data = (rd_plane == NIB_LO) ? lo_mem[rd_addr] : hi_mem[rd_addr];

endmodule

// File: rtl/moonbase_bus_responder.sv
// Target side of the 8-bit CPU pin bus: address latch, nibble sequencer,
// code/data nibble memory, device registers and a host loader port.
module moonbase_bus_responder
  import moonbase_bus_responder_pkg::*;
#(
  parameter int ADDR_BITS = 7,
  parameter int N_OUT_NIB = 4,
  parameter int N_IN_PAIR = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               bus_in,
  output logic [5:0]               bus_out,
  output logic [4*N_OUT_NIB-1:0]   gpio_out,
  input  logic [2*N_IN_PAIR-1:0]   gpio_in,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_BITS:0]       ld_addr,
  input  logic [7:0]               ld_data
);

  logic [ADDR_BITS-1:0] addr_q;
  nib_e                 nib_q;
  logic                 strobe;
  logic                 mem_we;
  logic                 dev_we;
  logic                 ld_we;
  logic [ADDR_BITS:0]   word_idx;
  logic [3:0]           mem_nib;
  logic [1:0]           dev_pair;

  assign strobe   = bus_in[STROBE];
  assign mem_we   = !strobe && !bus_in[RAM_WN];
  assign dev_we   = !strobe && !bus_in[DEV_WN];
  assign ld_ready = !mem_we;
  assign ld_we    = ld_valid && ld_ready;
  assign word_idx = {bus_in[SPACE], addr_q};

  // Reset does not gate the memory write; the CPU holds strobe high under reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      nib_q    <= NIB_LO;
      gpio_out <= '0;
    end else if (strobe) begin
      addr_q <= bus_in[ADDR_BITS-1:0];
      nib_q  <= NIB_LO;
    end else begin
      nib_q <= (nib_q == NIB_LO) ? NIB_HI : NIB_LO;
      if (dev_we) begin
        for (int i = 0; i < N_OUT_NIB; i++) begin
          if (addr_q == ADDR_BITS'(i)) gpio_out[4*i +: 4] <= bus_in[3:0];
        end
      end
    end
  end

  always_comb begin
    dev_pair = 2'b00;
    for (int i = 0; i < N_IN_PAIR; i++) begin
      if (addr_q == ADDR_BITS'(i)) dev_pair = gpio_in[2*i +: 2];
    end
  end

  moonbase_nibble_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk       (clk),
    .nib_we    (mem_we),
    .nib_plane (nib_q),
    .nib_addr  (word_idx),
    .nib_data  (bus_in[3:0]),
    .byte_we   (ld_we),
    .byte_addr (ld_addr),
    .byte_data (ld_data),
    .rd_plane  (nib_q),
    .rd_addr   (word_idx),
    .rd_data   (mem_nib)
  );

  assign bus_out = {dev_pair, strobe ? 4'h0 : mem_nib};

endmodule

// File: tb/tb_moonbase_bus_responder.sv
// Directed bench for moonbase_bus_responder: loader, nibble reads/writes,
// device registers, input pairs, loader back-pressure and reset behaviour.
module tb_moonbase_bus_responder;

  logic        clk;
  logic        reset;
  logic [7:0]  bus_in;
  logic [5:0]  bus_out;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;

  int checks;
  int passes;
  int fails;

  moonbase_bus_responder #(
    .ADDR_BITS(7),
    .N_OUT_NIB(4),
    .N_IN_PAIR(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // well before the next rising edge commits the cycle.
  task automatic apply_stimulus(input logic rst, input logic [7:0] b,
                                input logic v, input logic [7:0] a,
                                input logic [7:0] d);
    @(negedge clk);
    reset    = rst;
    bus_in   = b;
    ld_valid = v;
    ld_addr  = a;
    ld_data  = d;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0;
    reset = 1'b1; bus_in = 8'h80; ld_valid = 1'b0;
    ld_addr = 8'h00; ld_data = 8'h00; gpio_in = 16'h0000;

    // Loader runs while held in reset: code 0x05=A3, code 0x10=5E, code 0x00=71
    apply_stimulus(1, 8'h80, 1, 8'h85, 8'hA3);
    check_output("ld_ready_in_reset", 16'(ld_ready), 16'h1);
    apply_stimulus(1, 8'h80, 1, 8'h90, 8'h5E);
    apply_stimulus(1, 8'h80, 1, 8'h80, 8'h71);
    apply_stimulus(1, 8'h80, 0, 8'h00, 8'h00);
    check_output("reset_gpio_out", gpio_out, 16'h0000);
    check_output("reset_bus_out", 16'(bus_out), 16'h0000);

    // Code read of 0x05: lo, hi, then lo again
    apply_stimulus(0, 8'h85, 0, 8'h00, 8'h00);
    check_output("strobe_bus_nibble_zero", 16'(bus_out[3:0]), 16'h0);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("code05_lo", 16'(bus_out[3:0]), 16'h3);
    check_output("ld_ready_idle", 16'(ld_ready), 16'h1);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("code05_hi", 16'(bus_out[3:0]), 16'hA);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("code05_third_lo", 16'(bus_out[3:0]), 16'h3);

    // Two-nibble store into data 0x10, then read back data and code words
    apply_stimulus(0, 8'h90, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h16, 0, 8'h00, 8'h00);
    check_output("ld_ready_mem_write", 16'(ld_ready), 16'h0);
    apply_stimulus(0, 8'h19, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h90, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h30, 0, 8'h00, 8'h00);
    check_output("data10_lo", 16'(bus_out[3:0]), 16'h6);
    apply_stimulus(0, 8'h30, 0, 8'h00, 8'h00);
    check_output("data10_hi", 16'(bus_out[3:0]), 16'h9);
    apply_stimulus(0, 8'h90, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("code10_lo_kept", 16'(bus_out[3:0]), 16'hE);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("code10_hi_kept", 16'(bus_out[3:0]), 16'h5);

    // Device write to nibble 2, then an out-of-range device write to 7
    apply_stimulus(0, 8'h82, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h6C, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h87, 0, 8'h00, 8'h00);
    check_output("gpio_dev2", gpio_out, 16'h0C00);
    apply_stimulus(0, 8'h63, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h80, 0, 8'h00, 8'h00);
    check_output("gpio_out_of_range", gpio_out, 16'h0C00);

    // Input pairs from E400: pair6=10, pair7=11, pair3=00, addr 9 out of range
    gpio_in = 16'hE400;
    apply_stimulus(0, 8'h86, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("pair6", 16'(bus_out[5:4]), 16'h2);
    apply_stimulus(0, 8'h87, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("pair7", 16'(bus_out[5:4]), 16'h3);
    apply_stimulus(0, 8'h83, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("pair3", 16'(bus_out[5:4]), 16'h0);
    apply_stimulus(0, 8'h89, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("pair9_out_of_range", 16'(bus_out[5:4]), 16'h0);
    gpio_in = 16'h0000;

    // Loader held off by a CPU memory write to data 0x11, lands next cycle
    apply_stimulus(0, 8'h91, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h17, 1, 8'h20, 8'h4B);
    check_output("ld_ready_blocked", 16'(ld_ready), 16'h0);
    apply_stimulus(0, 8'h30, 1, 8'h20, 8'h4B);
    check_output("ld_ready_retry", 16'(ld_ready), 16'h1);
    apply_stimulus(0, 8'hA0, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h30, 0, 8'h00, 8'h00);
    check_output("load20_lo", 16'(bus_out[3:0]), 16'hB);
    apply_stimulus(0, 8'h30, 0, 8'h00, 8'h00);
    check_output("load20_hi", 16'(bus_out[3:0]), 16'h4);
    apply_stimulus(0, 8'h91, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h30, 0, 8'h00, 8'h00);
    check_output("cpu11_lo_intact", 16'(bus_out[3:0]), 16'h7);

    // Load into the word being read: old value now, new value next cycle
    apply_stimulus(0, 8'hA0, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h30, 1, 8'h20, 8'h5C);
    check_output("same_word_old_lo", 16'(bus_out[3:0]), 16'hB);
    apply_stimulus(0, 8'h30, 0, 8'h00, 8'h00);
    check_output("same_word_new_hi", 16'(bus_out[3:0]), 16'h5);
    apply_stimulus(0, 8'h30, 0, 8'h00, 8'h00);
    check_output("same_word_new_lo", 16'(bus_out[3:0]), 16'hC);

    // Device write to nibble 1, then reset mid-store
    apply_stimulus(0, 8'h81, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h65, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h85, 0, 8'h00, 8'h00);
    check_output("gpio_dev1", gpio_out, 16'h0C50);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    apply_stimulus(1, 8'h70, 0, 8'h00, 8'h00);
    check_output("read_hi_before_reset", 16'(bus_out[3:0]), 16'hA);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("gpio_after_reset", gpio_out, 16'h0000);
    check_output("nib_addr_cleared", 16'(bus_out[3:0]), 16'h1);
    apply_stimulus(0, 8'h85, 0, 8'h00, 8'h00);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("mem_kept_lo", 16'(bus_out[3:0]), 16'h3);
    apply_stimulus(0, 8'h70, 0, 8'h00, 8'h00);
    check_output("mem_kept_hi", 16'(bus_out[3:0]), 16'hA);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
